// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: sequencer state encoding and
// the default boot and halt addresses.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h00000000;

endpackage

// File: rtl/mips_bus_sequencer.sv
// Multi-cycle MIPS bus sequencer: fetches an instruction, optionally performs
// one load/store, commits the next PC, and stops when the halt address is reached.
module mips_bus_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  output logic [31:0]      address,
  output logic             read,
  output logic             write,
  input  logic             waitrequest,
  output logic [3:0]       byteenable,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  input  logic [31:0]      pc_next,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_be,
  output logic [31:0]      mem_rdata,
  output logic             reg_commit,
  output logic             active,
  output logic [CNT_W-1:0] instret
);

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic [31:0]        r_mem_rdata;
  logic [CNT_W-1:0]   r_instret;
  logic               r_active;
  logic               r_reg_commit;
  logic               r_read;
  logic               r_write;
  logic [31:0]        r_address;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;

  logic               w_done;
  logic               w_unused_addr_lsbs;

  // Requests are only ever raised in FETCH/MEM, so this is the completion strobe.
  assign w_done             = (r_read | r_write) & ~waitrequest;
  assign w_unused_addr_lsbs = ^mem_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_VECTOR;
      r_instr      <= '0;
      r_mem_rdata  <= '0;
      r_instret    <= '0;
      r_active     <= 1'b1;
      r_reg_commit <= 1'b0;
      r_read       <= 1'b1;
      r_write      <= 1'b0;
      r_address    <= {RESET_VECTOR[31:2], 2'b00};
      r_be         <= 4'hF;
      r_wdata      <= '0;
    end else if (clk_enable) begin
      case (r_state)
        FETCH: begin
          if (w_done) begin
            r_instr <= readdata;
            r_read  <= 1'b0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (mem_req) begin
            r_read    <= ~mem_we;
            r_write   <= mem_we;
            r_address <= {mem_addr[31:2], 2'b00};
            r_be      <= mem_be;
            r_wdata   <= mem_wdata;
            r_state   <= MEM;
          end else begin
            r_reg_commit <= 1'b1;
            r_state      <= COMMIT;
          end
        end
        MEM: begin
          if (w_done) begin
            if (r_read) r_mem_rdata <= readdata;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_reg_commit <= 1'b1;
            r_state      <= COMMIT;
          end
        end
        COMMIT: begin
          r_reg_commit <= 1'b0;
          r_pc         <= pc_next;
          r_instret    <= r_instret + CNT_W'(1);
          if (pc_next == HALT_ADDR) begin
            r_active <= 1'b0;
            r_state  <= HALT;
          end else begin
            // Pre-load the fetch request so it is on the bus the cycle FETCH starts.
            r_read    <= 1'b1;
            r_address <= {pc_next[31:2], 2'b00};
            r_be      <= 4'hF;
            r_state   <= FETCH;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign byteenable = r_be;
  assign writedata  = r_wdata;
  assign pc         = r_pc;
  assign instr      = r_instr;
  assign mem_rdata  = r_mem_rdata;
  assign reg_commit = r_reg_commit;
  assign active     = r_active;
  assign instret    = r_instret;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Self-checking bench for mips_bus_sequencer: directed scenarios plus random
// bus stalls and clock-enable gaps, compared every cycle against an instruction-level model.
module tb_mips_bus_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset, clk_enable, waitrequest;
  logic [31:0] address, writedata, readdata, pc, instr, pc_next;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        read, write, mem_req, mem_we, reg_commit, active;
  logic [3:0]  byteenable, mem_be, instret;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 0;

  // Model: which phase of the current instruction we are in
  // (0 fetch, 1 decode, 2 memory access, 3 retire) plus architectural state.
  int          m_step;
  bit          m_active;
  logic [31:0] m_pc, m_instr, m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          m_we;
  int          m_cnt;
  bit          e_rd, e_wr, e_cm;

  mips_bus_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .pc(pc), .instr(instr), .pc_next(pc_next),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .reg_commit(reg_commit), .active(active), .instret(instret)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference model advanced on each rising edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_step = 0; m_active = 1; m_pc = RV; m_instr = 0; m_rdata = 0;
      m_cnt = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    end else if (clk_enable && m_active) begin
      case (m_step)
        0: if (!waitrequest) begin m_instr = readdata; m_step = 1; end
        1: begin
          if (mem_req) begin
            m_we = mem_we; m_addr = {mem_addr[31:2], 2'b00};
            m_be = mem_be; m_wdata = mem_wdata; m_step = 2;
          end else m_step = 3;
        end
        2: if (!waitrequest) begin
          if (!m_we) m_rdata = readdata;
          m_step = 3;
        end
        default: begin
          m_pc  = pc_next;
          m_cnt = (m_cnt + 1) % 16;
          if (pc_next == 32'h0) m_active = 0;
          else m_step = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      e_rd = m_active && (m_step == 0 || (m_step == 2 && !m_we));
      e_wr = m_active && m_step == 2 && m_we;
      e_cm = m_active && m_step == 3;
      chk("read", 32'(read), 32'(e_rd));
      chk("write", 32'(write), 32'(e_wr));
      chk("reg_commit", 32'(reg_commit), 32'(e_cm));
      chk("active", 32'(active), 32'(m_active));
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      chk("mem_rdata", mem_rdata, m_rdata);
      chk("instret", 32'(instret), 32'(m_cnt));
      if (e_rd || e_wr) begin
        chk("address", address, (m_step == 0) ? {m_pc[31:2], 2'b00} : m_addr);
        chk("byteenable", 32'(byteenable), (m_step == 0) ? 32'hF : 32'(m_be));
      end
      if (e_wr) chk("writedata", writedata, m_wdata);
    end
  end

  logic [31:0] t;
  bit          found;

  initial begin
    reset = 1; clk_enable = 1; waitrequest = 0; readdata = 0; pc_next = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_be = 0;
    tick(); tick();
    chk_on = 1;

    // Simple non-memory instruction.
    reset = 0; readdata = 32'h2402000A; pc_next = 32'hBFC00004;
    @(negedge clk);
    chk("lit_first_read", 32'(read), 32'h1);
    chk("lit_first_addr", address, 32'hBFC00000);
    chk("lit_reset_instret", 32'(instret), 32'h0);
    tick(); @(negedge clk);
    chk("lit_instr_latched", instr, 32'h2402000A);
    tick(); @(negedge clk);
    chk("lit_commit_cycle3", 32'(reg_commit), 32'h1);
    tick();
    mem_req = 1; mem_we = 0; mem_addr = 32'h1003; mem_be = 4'hF;
    pc_next = 32'hBFC00008; readdata = 32'h8C820000;
    @(negedge clk);
    chk("lit_next_fetch", address, 32'hBFC00004);
    chk("lit_instret_one", 32'(instret), 32'h1);

    // Load with three stalled cycles.
    tick(); waitrequest = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin waitrequest = 0; readdata = 32'hCAFEF00D; end
      @(negedge clk);
      chk("lit_load_addr_hold", address, 32'h00001000);
    end
    tick(); @(negedge clk);
    chk("lit_load_data", mem_rdata, 32'hCAFEF00D);
    chk("lit_load_commit", 32'(reg_commit), 32'h1);

    // Store.
    tick();
    mem_we = 1; mem_wdata = 32'hDEADBEEF; mem_be = 4'b0011; mem_addr = 32'h2000;
    pc_next = 32'hBFC0000C; readdata = 32'h0;
    tick(); tick(); @(negedge clk);
    chk("lit_store_write", 32'(write), 32'h1);
    chk("lit_store_noread", 32'(read), 32'h0);
    chk("lit_store_data", writedata, 32'hDEADBEEF);
    chk("lit_store_be", 32'(byteenable), 32'h3);
    tick(); @(negedge clk);
    chk("lit_store_single", 32'(write), 32'h0);

    // Clock-enable gap in the middle of a load.
    tick();
    mem_we = 0; mem_addr = 32'h3000; mem_be = 4'hF; pc_next = 32'hBFC00010;
    tick(); waitrequest = 1;
    tick(); clk_enable = 0; waitrequest = 0; readdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) clk_enable = 1;
      @(negedge clk);
      chk("lit_freeze_addr", address, 32'h00003000);
      chk("lit_freeze_rdata", mem_rdata, 32'hCAFEF00D);
    end
    tick(); @(negedge clk);
    chk("lit_after_freeze", mem_rdata, 32'h12345678);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      reset       = ($urandom_range(0, 150) == 0);
      waitrequest = ($urandom_range(0, 2) == 0);
      clk_enable  = ($urandom_range(0, 7) != 0);
      readdata    = $urandom;
      if (m_step == 0) begin
        mem_req = $urandom_range(0, 1) == 1; mem_we = $urandom_range(0, 1) == 1;
        mem_addr = $urandom; mem_wdata = $urandom; mem_be = 4'($urandom_range(0, 15));
        t = $urandom;
        pc_next = ($urandom_range(0, 3) == 0) ? {t[31:2], 2'b00} : m_pc + 32'd4;
        if (pc_next == 32'h0) pc_next = 32'h4;
      end
    end

    // Reset during a stalled fetch.
    reset = 0; found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      clk_enable = 1; waitrequest = 0; mem_req = 0;
      if (m_step == 0) begin waitrequest = 1; found = 1; end
    end
    if (!found) begin n_checks++; n_err++; $display("FAIL seek_fetch: got timeout expected fetch phase"); end
    tick(); @(negedge clk);
    chk("lit_stalled_fetch", 32'(read), 32'h1);
    reset = 1; tick(); reset = 0; waitrequest = 0;
    @(negedge clk);
    chk("lit_reset_addr", address, RV);
    chk("lit_reset_instret2", 32'(instret), 32'h0);

    // Counter wrap with a 4-bit counter.
    for (int c = 0; c < 45; c++) begin
      pc_next = m_pc + 32'd4; mem_req = 0;
      tick();
    end
    @(negedge clk);
    chk("lit_instret_ones", 32'(instret), 32'hF);
    for (int c = 0; c < 3; c++) begin pc_next = m_pc + 32'd4; tick(); end
    @(negedge clk);
    chk("lit_instret_wrap", 32'(instret), 32'h0);

    // Halt.
    pc_next = 32'h0;
    tick(); tick(); @(negedge clk);
    chk("lit_halt_commit", 32'(reg_commit), 32'h1);
    tick(); @(negedge clk);
    chk("lit_halt_active", 32'(active), 32'h0);
    chk("lit_halt_pc", pc, 32'h0);
    for (int c = 0; c < 20; c++) begin
      tick();
      waitrequest = $urandom_range(0, 1) == 1; readdata = $urandom;
      @(negedge clk);
      chk("lit_halt_nobus", 32'(read | write), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_sequencer.md
MIPS_BUS_SEQUENCER -- requirements
Module: mips_bus_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter HALT_ADDR, default 32'h00000000, meaning a committed PC equal to this value halts the CPU.
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the retired-instruction counter.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 clk_enable  in  1  when low, every register holds its value.
REQ-007 address  out  32  bus word address, bits [1:0] always 0.
REQ-008 read  out  1  bus read request.
REQ-009 write  out  1  bus write request.
REQ-010 waitrequest  in  1  slave stall; a transfer completes on a cycle with request high and waitrequest low.
REQ-011 byteenable  out  4  bus byte lanes.
REQ-012 writedata  out  32  bus store data.
REQ-013 readdata  in  32  bus load/fetch data.
REQ-014 pc  out  32  current PC.
REQ-015 instr  out  32  latched instruction register.
REQ-016 pc_next  in  32  next PC from the datapath, delay slot already resolved.
REQ-017 mem_req, mem_we  in  1 each  datapath requests a load (we=0) or store (we=1) for the current instruction.
REQ-018 mem_addr, mem_wdata  in  32 each;  mem_be  in  4  datapath access address, store data, byte lanes.
REQ-019 mem_rdata  out  32  latched load data.
REQ-020 reg_commit  out  1  one-cycle register-file write strobe.
REQ-021 active  out  1  high from reset until halt.
REQ-022 instret  out  CNT_W  retired-instruction count.

Function
REQ-023 FSM states SHALL be FETCH, EXEC, MEM, COMMIT, HALT.
REQ-024 FETCH: read=1, address=pc, byteenable=4'hF; on completion latch readdata into instr and go to EXEC; otherwise stay.
REQ-025 EXEC: one cycle, no bus request; go to MEM if mem_req=1, else to COMMIT.
REQ-026 MEM: read=!mem_we, write=mem_we, address={mem_addr[31:2],2'b00}, byteenable=mem_be, writedata=mem_wdata; on completion latch readdata into mem_rdata for loads and go to COMMIT.
REQ-027 COMMIT: reg_commit=1, pc<=pc_next, instret<=instret+1 (wrapping modulo 2^CNT_W); go to HALT if pc_next==HALT_ADDR, else FETCH.
REQ-028 HALT: active=0, no bus requests, all registers frozen until reset.
REQ-029 read and write SHALL never be high in the same cycle; both SHALL be 0 outside FETCH and MEM.
REQ-030 Bus outputs SHALL stay stable while waitrequest=1.
REQ-031 clk_enable=0 SHALL freeze state, pc, instr, mem_rdata, instret; bus outputs keep their current values; completion is not sampled.
REQ-032 Minimum latency: 3 cycles per non-memory instruction, 4 per load/store, with waitrequest=0.
REQ-033 mem_req sampled only in EXEC; mem_addr, mem_wdata, mem_be and mem_we SHALL be held by the datapath through MEM.

Reset
REQ-034 On reset: state=FETCH, pc=RESET_VECTOR, instr=0, mem_rdata=0, instret=0, active=1, reg_commit=0.
REQ-035 Reset SHALL take priority over clk_enable and abort any in-flight transfer; read=1 at address RESET_VECTOR on the first cycle after reset.

Structure
REQ-036 The state enum and default RESET_VECTOR/HALT_ADDR constants SHALL live in shared package mips_pkg.
REQ-037 Single FSM module; no sub-module required.

Verification
REQ-038 Reset, waitrequest=0, readdata=32'h2402000A, mem_req=0, pc_next=pc+4 -> read at 32'hBFC00000, reg_commit at cycle 3, next fetch at 32'hBFC00004, instret=1.
REQ-039 Load with mem_addr=32'h1003, mem_be=4'hF, waitrequest high for 3 cycles -> address=32'h1000 held stable for 4 cycles, mem_rdata latched on the 4th cycle, commit on the next cycle.
REQ-040 Store with mem_wdata=32'hDEADBEEF, mem_be=4'b0011 -> single write cycle with those values, read=0 throughout.
REQ-041 pc_next=32'h0 in COMMIT -> active=0 on the next cycle, no further bus requests for 20 cycles.
REQ-042 clk_enable=0 for 5 cycles in the middle of MEM -> outputs unchanged, transfer completes after clk_enable returns high.
REQ-043 Reset asserted during a stalled fetch -> read restarts at RESET_VECTOR, instret=0; instret preset to all ones then incremented once -> 0.
